// File: rtl/bp_pkg.sv
// Shared branch-predictor types: 2-bit saturating counter state, its step function
// and the table entry layout.
package bp_pkg;

   // Widest tag any table instance may store; narrower tags are zero-extended.
   localparam int BHT_TAG_W = 16;

   typedef enum logic [1:0] {
      SNT = 2'd0,
      WNT = 2'd1,
      WT  = 2'd2,
      ST  = 2'd3
   } bht_cnt_t;

   typedef struct packed {
      logic                 valid;
      logic [BHT_TAG_W-1:0] tag;
      bht_cnt_t             cnt;
   } bht_entry_t;

   function automatic bht_cnt_t bht_next(input bht_cnt_t c, input logic taken);
      bht_cnt_t n;
      n = c;
      case (c)
         SNT:     n = taken ? WNT : SNT;
         WNT:     n = taken ? WT  : SNT;
         WT:      n = taken ? ST  : WNT;
         ST:      n = taken ? ST  : WT;
         default: n = WNT;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/sat_stat_counter.sv
// Saturating event counter with synchronous clear; count visible one cycle after inc.
// No backpressure: holds at all-ones instead of wrapping.
module sat_stat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_clr,
   input  logic         i_inc,
   output logic [W-1:0] o_cnt
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != '1)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/branch_history_table.sv
// Tagged 2-bit-counter branch predictor with optional gshare indexing and statistics.
// Latency: lookup is combinational, training lands at the clock edge; no backpressure.
module branch_history_table
   import bp_pkg::*;
#(
   parameter int PC_W       = 10,
   parameter int INDEX_BITS = 5,
   parameter int USE_GSHARE = 0,
   parameter int HIST_BITS  = 4,
   parameter int STAT_W     = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [PC_W-1:0]      lookup_pc,
   output logic                 prediction,
   output logic                 pred_hit,
   output logic [HIST_BITS-1:0] pred_hist,
   input  logic                 update_en,
   input  logic [PC_W-1:0]      update_pc,
   input  logic [HIST_BITS-1:0] update_hist,
   input  logic                 update_taken,
   input  logic                 update_predicted,
   input  logic                 stat_clr,
   output logic [STAT_W-1:0]    stat_updates,
   output logic [STAT_W-1:0]    stat_mispredicts
);

   localparam int ENTRIES = 1 << INDEX_BITS;

   bht_entry_t             r_tbl [ENTRIES];
   logic [HIST_BITS-1:0]   r_ghr;

   logic [INDEX_BITS-1:0]  w_lk_idx;
   logic [INDEX_BITS-1:0]  w_up_idx;
   logic [BHT_TAG_W-1:0]   w_lk_tag;
   logic [BHT_TAG_W-1:0]   w_up_tag;
   bht_entry_t             w_lk_ent;
   bht_entry_t             w_up_ent;
   logic                   w_lk_hit;
   logic                   w_up_hit;
   logic [HIST_BITS-1:0]   w_ghr_nxt;
   logic                   w_mispredict;

   // gshare folds the zero-extended history into the low PC bits; otherwise plain PC bits.
   function automatic logic [INDEX_BITS-1:0] f_index(input logic [PC_W-1:0]      pc,
                                                     input logic [HIST_BITS-1:0] hist);
      logic [INDEX_BITS-1:0] hx;
      hx = (USE_GSHARE != 0) ? INDEX_BITS'(hist) : '0;
      return pc[INDEX_BITS-1:0] ^ hx;
   endfunction

   assign w_lk_idx = f_index(lookup_pc, r_ghr);
   assign w_up_idx = f_index(update_pc, update_hist);
   assign w_lk_tag = BHT_TAG_W'(lookup_pc[PC_W-1:INDEX_BITS]);
   assign w_up_tag = BHT_TAG_W'(update_pc[PC_W-1:INDEX_BITS]);

   // Lookup sees the pre-update entry when both ports hit the same index.
   assign w_lk_ent = r_tbl[w_lk_idx];
   assign w_up_ent = r_tbl[w_up_idx];
   assign w_lk_hit = w_lk_ent.valid && (w_lk_ent.tag == w_lk_tag);
   assign w_up_hit = w_up_ent.valid && (w_up_ent.tag == w_up_tag);

   assign prediction = w_lk_hit & w_lk_ent.cnt[1];
   assign pred_hit   = w_lk_hit;
   assign pred_hist  = r_ghr;

   // Truncating {ghr, taken} keeps the newest HIST_BITS outcomes, also for HIST_BITS=1.
   assign w_ghr_nxt = HIST_BITS'({r_ghr, update_taken});

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_tbl[i] <= '{valid: 1'b0, tag: '0, cnt: WNT};
         end
         r_ghr <= '0;
      end else if (update_en) begin
         if (w_up_hit) begin
            r_tbl[w_up_idx].cnt <= bht_next(w_up_ent.cnt, update_taken);
         end else begin
            r_tbl[w_up_idx] <= '{valid: 1'b1,
                                 tag:   w_up_tag,
                                 cnt:   (update_taken ? WT : WNT)};
         end
         r_ghr <= w_ghr_nxt;
      end
   end

   assign w_mispredict = update_en & (update_taken ^ update_predicted);

   sat_stat_counter #(.W(STAT_W)) u_stat_updates (
      .clk   (clk),
      .rst   (rst),
      .i_clr (stat_clr),
      .i_inc (update_en),
      .o_cnt (stat_updates)
   );

   sat_stat_counter #(.W(STAT_W)) u_stat_mispredicts (
      .clk   (clk),
      .rst   (rst),
      .i_clr (stat_clr),
      .i_inc (w_mispredict),
      .o_cnt (stat_mispredicts)
   );

endmodule
